// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: loader states, RAM geometry
// and the frame header mask.
package program_loader_pkg;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DW     = 8;

  // Header bits 7:5 must be zero for a frame to be accepted.
  localparam logic [DW-1:0] HDR_MASK = 8'hE0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_t;
endpackage

// File: rtl/program_ram.sv
// 32 x 8 program RAM: one synchronous write port, one registered read port.
// Only the read register is reset; the array keeps its contents.
module program_ram
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DW-1:0]     i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DW-1:0]     o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read-during-write to the same word returns the old contents.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/program_loader.sv
// Loads a framed, checksummed byte stream into program RAM and releases the
// CPU from reset only after a verified load; then serves CPU RAM accesses.
module program_loader
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        R,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [4:0]  mem_addr,
  input  logic        mem_wr_en,
  input  logic [7:0]  mem_wr_data,
  output logic [7:0]  mem_rd_data,
  output logic        cpu_R,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_last;
  logic [DW-1:0]     r_sum;
  logic [DW-1:0]     w_sum_next;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_cpu_R;
  logic              r_done;
  logic              r_err;
  logic              w_accept;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DW-1:0]     w_ram_data;

  assign w_accept   = in_valid & r_in_ready;
  assign w_sum_next = r_sum + in_data;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERR: if (load_start) w_next = ST_HDR;
      ST_HDR:  if (w_accept) w_next = ((in_data & HDR_MASK) == '0) ? ST_DATA : ST_ERR;
      ST_DATA: if (w_accept && (r_idx == r_last)) w_next = ST_CSUM;
      ST_CSUM: if (w_accept) w_next = (w_sum_next == '0) ? ST_RUN : ST_ERR;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they stay registered yet
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!R) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_last     <= '0;
      r_sum      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_cpu_R    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == ST_HDR) || (w_next == ST_DATA) || (w_next == ST_CSUM);
      r_busy     <= (w_next == ST_HDR) || (w_next == ST_DATA) || (w_next == ST_CSUM);
      r_cpu_R    <= (w_next != ST_RUN);
      r_done     <= (w_next == ST_RUN);
      r_err      <= (w_next == ST_ERR);
      if ((r_state == ST_HDR) && w_accept) begin
        r_last <= in_data[ADDR_W-1:0];
        r_sum  <= '0;
        r_idx  <= '0;
      end
      if ((r_state == ST_DATA) && w_accept) begin
        r_sum <= w_sum_next;
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Stream owns the write port in DATA, the CPU in RUN; nothing writes in reset.
  assign w_ram_we   = R & (((r_state == ST_DATA) && w_accept) ||
                           ((r_state == ST_RUN) && mem_wr_en));
  assign w_ram_addr = (r_state == ST_DATA) ? r_idx : mem_addr;
  assign w_ram_data = (r_state == ST_DATA) ? in_data : mem_wr_data;

  program_ram u_ram (
    .clk     (clk),
    .i_rst_n (R),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_addr),
    .i_wdata (w_ram_data),
    .i_raddr (mem_addr),
    .o_rdata (mem_rd_data)
  );

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign cpu_R    = r_cpu_R;
  assign done     = r_done;
  assign err      = r_err;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a vector table for the main flows plus
// hand-written sequences for backpressure, reset mid-frame and reload.
module tb_program_loader;
  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [4:0] mem_addr = '0;
  logic       mem_wr_en = 1'b0;
  logic [7:0] mem_wr_data = '0;
  logic [7:0] mem_rd_data;
  logic       cpu_R, busy, done, err;

  // Status code order: {in_ready, cpu_R, busy, done, err}
  localparam logic [4:0] S_IDLE = 5'b01000;
  localparam logic [4:0] S_BUSY = 5'b11100;
  localparam logic [4:0] S_RUN  = 5'b00010;
  localparam logic [4:0] S_ERR  = 5'b01001;

  typedef struct {
    logic       r, ls, v;
    logic [7:0] d;
    logic [4:0] a;
    logic       we;
    logic [7:0] wd;
    logic [4:0] st;
    logic       crd;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  program_loader dut (
    .clk         (clk),
    .R           (R),
    .load_start  (load_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .cpu_R       (cpu_R),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic ls, input logic v,
                              input logic [7:0] d, input logic [4:0] a,
                              input logic we, input logic [7:0] wd,
                              input logic [4:0] st, input logic crd,
                              input logic [7:0] rd);
    vec_t x;
    x.r = r; x.ls = ls; x.v = v; x.d = d; x.a = a;
    x.we = we; x.wd = wd; x.st = st; x.crd = crd; x.rd = rd;
    return x;
  endfunction

  task automatic apply(input vec_t x, input string tag);
    logic [4:0] act;
    R = x.r; load_start = x.ls; in_valid = x.v; in_data = x.d;
    mem_addr = x.a; mem_wr_en = x.we; mem_wr_data = x.wd;
    @(posedge clk);
    #1;
    act = {in_ready, cpu_R, busy, done, err};
    n_checks++;
    if (act === x.st) n_pass++;
    else $display("FAIL %s status {rdy,cpuR,busy,done,err}: got %b expected %b", tag, act, x.st);
    if (x.crd) begin
      n_checks++;
      if (mem_rd_data === x.rd) n_pass++;
      else $display("FAIL %s rd_data: got %02h expected %02h", tag, mem_rd_data, x.rd);
    end
  endtask

  // Stream one byte with no read check.
  task automatic sbyte(input logic [7:0] b, input logic [4:0] st, input string tag);
    apply(mk(1, 0, 1, b, 0, 0, 0, st, 0, 0), tag);
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [4:0] st, input logic [7:0] rd,
                        input string tag);
    apply(mk(1, 0, 0, 8'h00, a, 0, 0, st, 1, rd), tag);
  endtask

  initial begin
    // Reset and idle
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, S_IDLE, 1, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'h55, 0, 0, 8'h00, S_IDLE, 1, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'hAA, 0, 0, 8'h00, S_IDLE, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, S_IDLE, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h33, 0, 0, 8'h00, S_IDLE, 0, 8'h00));
    // Good load: hdr 02, data 21 10 05, csum CA
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h02, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h21, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h10, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h05, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'hCA, 0, 0, 8'h00, S_RUN,  0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h00, S_RUN,  1, 8'h10));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, S_RUN,  1, 8'h21));
    tbl.push_back(mk(1, 0, 0, 8'h00, 2, 0, 8'h00, S_RUN,  1, 8'h05));
    // CPU write in RUN, then read-during-write returns old data
    tbl.push_back(mk(1, 0, 0, 8'h00, 4, 1, 8'h77, S_RUN,  0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4, 0, 8'h00, S_RUN,  1, 8'h77));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4, 1, 8'h88, S_RUN,  1, 8'h77));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4, 0, 8'h00, S_RUN,  1, 8'h88));
    // Bad checksum
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h02, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h21, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h10, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h05, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'hCB, 0, 0, 8'h00, S_ERR,  0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, S_ERR,  1, 8'h21));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h00, S_ERR,  1, 8'h10));
    tbl.push_back(mk(1, 0, 0, 8'h00, 2, 0, 8'h00, S_ERR,  1, 8'h05));
    // CPU write outside RUN is dropped
    tbl.push_back(mk(1, 0, 0, 8'h00, 4, 1, 8'h99, S_ERR,  1, 8'h88));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4, 0, 8'h00, S_ERR,  1, 8'h88));
    // Bad header, then bytes ignored while in_ready is low
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h40, 0, 0, 8'h00, S_ERR,  0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h11, 0, 0, 8'h00, S_ERR,  1, 8'h21));
    // N=1 frame with load_start mid-frame ignored
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h00, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 1, 1, 8'h5A, 0, 0, 8'h00, S_BUSY, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'hA6, 0, 0, 8'h00, S_RUN,  0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, S_RUN,  1, 8'h5A));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h00, S_RUN,  1, 8'h10));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Backpressure: bytes while not ready, then the good frame with 3-cycle gaps
    sbyte(8'hEE, S_RUN, "bp_preready0");
    sbyte(8'hEE, S_RUN, "bp_preready1");
    rd_chk(0, S_RUN, 8'h5A, "bp_prestored");
    apply(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, S_BUSY, 0, 8'h00), "bp_start");
    begin
      logic [7:0] frame [5];
      frame[0] = 8'h02; frame[1] = 8'h21; frame[2] = 8'h10;
      frame[3] = 8'h05; frame[4] = 8'hCA;
      for (int b = 0; b < 5; b++) begin
        for (int g = 0; g < 3; g++) begin
          apply(mk(1, 0, 0, 8'hFF, 0, 0, 8'h00, S_BUSY, 0, 8'h00),
                $sformatf("bp_gap%0d_%0d", b, g));
        end
        sbyte(frame[b], (b == 4) ? S_RUN : S_BUSY, $sformatf("bp_byte%0d", b));
      end
    end
    rd_chk(0, S_RUN, 8'h21, "bp_rd0");
    rd_chk(1, S_RUN, 8'h10, "bp_rd1");
    rd_chk(2, S_RUN, 8'h05, "bp_rd2");
    rd_chk(4, S_RUN, 8'h88, "bp_rd4");

    // Reset mid-DATA: written byte survives, outputs return to reset values
    apply(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, S_BUSY, 0, 8'h00), "rst_start");
    sbyte(8'h02, S_BUSY, "rst_hdr");
    sbyte(8'h3C, S_BUSY, "rst_d0");
    apply(mk(0, 0, 1, 8'h44, 0, 0, 8'h00, S_IDLE, 1, 8'h00), "rst_assert");
    rd_chk(0, S_IDLE, 8'h3C, "rst_kept0");
    rd_chk(1, S_IDLE, 8'h10, "rst_kept1");

    // Reload, then load_start in RUN re-holds the CPU
    apply(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, S_BUSY, 0, 8'h00), "rl_start");
    sbyte(8'h02, S_BUSY, "rl_hdr");
    sbyte(8'h21, S_BUSY, "rl_d0");
    sbyte(8'h10, S_BUSY, "rl_d1");
    sbyte(8'h05, S_BUSY, "rl_d2");
    sbyte(8'hCA, S_RUN,  "rl_csum");
    apply(mk(1, 0, 0, 8'h00, 4, 1, 8'h66, S_RUN, 1, 8'h88), "rl_wr4");
    rd_chk(4, S_RUN, 8'h66, "rl_rd4");
    apply(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, S_BUSY, 1, 8'h21), "rl_restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
